invsqrt_stream_stage: RTL and testbench

Streaming wrapper around `invsqrt_pipeline`.
- Upstream: accepts IEEE-754 single-precision operands on a valid/ready stream.
- Special cases: screens out zero, denormal, negative, infinity and NaN operands and replaces them with a benign operand.
- Pipeline control: drives the pipeline's `ce` and operand input.
- Downstream: re-attaches the sign bit, substitutes the special-case results, and presents results on a valid/ready stream through a 2-entry output buffer.

---
 rtl/invsqrt_pkg.sv | 40 ++++
 rtl/invsqrt_out_fifo.sv | 43 ++++
 rtl/invsqrt_stream_stage.sv | 65 ++++++
 tb/tb_invsqrt_stream_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/invsqrt_pkg.sv
// rtl/invsqrt_pkg.sv - shared types, constants and classifier for the inverse-sqrt stream stage
package invsqrt_pkg;

    typedef enum logic [1:0] {
        OV_NONE = 2'd0,
        OV_INF  = 2'd1,
        OV_ZERO = 2'd2,
        OV_NAN  = 2'd3
    } ov_t;

    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

    typedef struct packed {
        logic valid;
        ov_t  ov;
    } tag_t;

    // Zero/denormal is tested first so -0 and negative denormals give +inf, not NaN.
    function automatic ov_t classify(input logic [31:0] x);
        if (x[30:23] == 8'h00)                      return OV_INF;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0)  return OV_NAN;
        if (x[31])                                  return OV_NAN;
        if (x[30:23] == 8'hFF)                      return OV_ZERO;
        return OV_NONE;
    endfunction

    // The pipeline only ever sees positive operands, so its sign is always 0.
    function automatic logic [31:0] format_result(input ov_t ov, input logic [30:0] p);
        case (ov)
            OV_INF:  return FP_POS_INF;
            OV_ZERO: return FP_ZERO;
            OV_NAN:  return FP_QNAN;
            default: return {1'b0, p};
        endcase
    endfunction

endpackage

// File: rtl/invsqrt_out_fifo.sv
// rtl/invsqrt_out_fifo.sv - 2-entry result buffer for the inverse-sqrt stream stage
module invsqrt_out_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    // A push into a full buffer is only taken when the head leaves on the same edge.
    assign do_push = push && (count != 2'd2 || pop);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/invsqrt_stream_stage.sv
// rtl/invsqrt_stream_stage.sv - valid/ready wrapper around invsqrt_pipeline with special-case handling
module invsqrt_stream_stage
    import invsqrt_pkg::*;
#(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        pipe_ce,
    output logic [31:0] pipe_in,
    input  logic [30:0] pipe_out,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data
);

    tag_t        tags [LATENCY];
    tag_t        tail;
    ov_t         s_ov;
    logic [1:0]  fifo_count;
    logic        push;
    logic [31:0] push_data;

    // Idle cycles are not classified so their tags never carry an override.
    assign s_ov    = s_valid ? classify(s_data) : OV_NONE;
    assign pipe_in = (s_ov == OV_NONE) ? s_data : FP_ONE;

    // The pipeline runs freely and only stalls when a valid result has nowhere to go.
    assign tail    = tags[LATENCY-1];
    assign pipe_ce = rst_n & (!tail.valid | (fifo_count < 2'd2) | m_ready);
    assign s_ready = pipe_ce;

    assign push      = pipe_ce & tail.valid;
    assign push_data = format_result(tail.ov, pipe_out);

    // Tags travel alongside the pipeline data and freeze with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else if (pipe_ce) begin
            tags[0] <= tag_t'{valid: s_valid, ov: s_ov};
            for (int i = 1; i < LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    invsqrt_out_fifo u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (m_valid & m_ready),
        .head      (m_data),
        .count     (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0);

endmodule

// File: tb/tb_invsqrt_stream_stage.sv
// tb/tb_invsqrt_stream_stage.sv - scoreboard bench for invsqrt_stream_stage with a pipeline stand-in
module tb_invsqrt_stream_stage;

    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        m_ready = 1'b0;
    logic        s_ready;
    logic        pipe_ce;
    logic [31:0] pipe_in;
    logic [30:0] pipe_out;
    logic        m_valid;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    invsqrt_stream_stage #(.LATENCY(L)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .pipe_ce  (pipe_ce),
        .pipe_in  (pipe_in),
        .pipe_out (pipe_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
    );

    // Stand-in for invsqrt_pipeline: exact results for the operands used here, a marker otherwise.
    function automatic logic [31:0] isq(input logic [31:0] x);
        case (x)
            32'h3F800000: return 32'h3F800000;
            32'h40800000: return 32'h3F000000;
            32'h41800000: return 32'h3E800000;
            32'h3E800000: return 32'h40000000;
            32'h42800000: return 32'h3E000000;
            32'h40000000: return 32'h3F3504F3;
            default:      return 32'h7FFFFFFF;
        endcase
    endfunction

    logic [31:0] isq_now;
    logic [30:0] stg [L];
    assign isq_now  = isq(pipe_in);
    assign pipe_out = stg[L-1];

    // L ce-gated stages, stage 0 loads on the accepting edge.
    always @(posedge clk) begin
        if (pipe_ce) begin
            stg[0] <= isq_now[30:0];
            for (int i = 1; i < L; i++) stg[i] <= stg[i-1];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   accepted = 0;
    bit   lat_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", m_data, 32'hDEADBEEF);
            end else begin
                chk("result", m_data, exp_q[0].d);
                if (m_ready) begin
                    if (lat_chk) chk("latency", 32'(cyc), 32'(exp_q[0].acc + L + 1));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; holds the operand until accepted, returns at posedge+1.
    task automatic send(input logic [31:0] d, input logic [31:0] e);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back('{d: e, acc: cyc});
                accepted++;
                break;
            end
            n++;
            if (n > 200) begin
                timeout("accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) timeout("drain");
    endtask

    logic [31:0] ops_n   [3]  = '{32'h40800000, 32'h3F800000, 32'h41800000};
    logic [31:0] res_n   [3]  = '{32'h3F000000, 32'h3F800000, 32'h3E800000};
    logic [31:0] ops_s   [6]  = '{32'h00000000, 32'h80000000, 32'h00000001,
                                   32'h7F800000, 32'hC0800000, 32'h7FC00001};
    logic [31:0] res_s   [6]  = '{32'h7F800000, 32'h7F800000, 32'h7F800000,
                                   32'h00000000, 32'h7FC00000, 32'h7FC00000};
    logic [31:0] ops_r   [10] = '{32'h40800000, 32'h3F800000, 32'h41800000, 32'h3E800000,
                                   32'h42800000, 32'h00000000, 32'h7F800000, 32'hC0800000,
                                   32'h007FFFFF, 32'hFF800000};
    logic [31:0] res_r   [10] = '{32'h3F000000, 32'h3F800000, 32'h3E800000, 32'h40000000,
                                   32'h3E000000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                                   32'h7F800000, 32'h7FC00000};

    bit rand_done;

    initial begin
        // Reset state.
        step(2);
        @(negedge clk);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_pipe_ce", {31'd0, pipe_ce}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("pipe_ce_after_rst", {31'd0, pipe_ce}, 32'd1);
        @(posedge clk);
        #1;

        // Normal and special operands, back to back, with latency checked.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) send(ops_n[i], res_n[i]);
        for (int i = 0; i < 6; i++) send(ops_s[i], res_s[i]);
        wait_empty(40);

        // Drain: one operand, then idle.
        send(32'h40000000, 32'h3F3504F3);
        wait_empty(20);
        lat_chk = 1'b0;

        // Back-pressure: 10 operands, m_ready low for 8 cycles mid-stream.
        begin
            int base;
            base = accepted;
            fork
                for (int i = 0; i < 10; i++) send(ops_r[i], res_r[i]);
                begin
                    int n;
                    n = 0;
                    while (accepted < base + 3 && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    @(posedge clk);
                    #1;
                    m_ready = 1'b0;
                    step(7);
                    @(negedge clk);
                    chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
                    chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
                    @(posedge clk);
                    #1;
                    m_ready = 1'b1;
                end
            join
        end
        wait_empty(60);

        // Random stress over the known operand table.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int k;
                    k = $urandom_range(0, 9);
                    send(ops_r[k], res_r[k]);
                    step($urandom_range(0, 2));
                end
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                m_ready = 1'($urandom_range(0, 1));
                step(1);
            end
        join
        m_ready = 1'b1;
        wait_empty(60);

        // Reset mid-stream: 2 buffered, 3 in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(ops_r[i], res_r[i]);
        step(4);
        @(negedge clk);
        chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
        chk("pre_rst_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        step(12);
        lat_chk = 1'b1;
        send(32'h41800000, 32'h3E800000);
        wait_empty(20);
        chk("final_m_valid", {31'd0, m_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
